chnl_tx_arbiter: RTL and testbench

- Shares one RIFFA TX channel (CHNL_TX_* on the riffa_pango endpoint) between C_NUM_REQ user requesters, using round-robin arbitration.
- Sequences each transaction: raises CHNL_TX with the granted requester's LEN/OFF/LAST, waits for CHNL_TX_ACK, counts data beats until LEN is satisfied, then releases the channel.
- Sits between the user cores (in place of a single chnl_tester TX side) and the endpoint. It runs in the channel clock domain (CHNL_TX_CLK = CLK).

---
 rtl/chnl_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_chnl_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_tx_arbiter.sv
// chnl_tx_arbiter: round-robin sharing of one RIFFA TX channel between
// C_NUM_REQ requesters. Each grant raises CHNL_TX with the winner's
// LEN/OFF/LAST, waits for ACK, forwards ceil(LEN/W) data beats, then releases.
// Optional stall watchdog: define CHNL_TX_ARB_TIMEOUT_EN (limit C_TIMEOUT cycles).
module chnl_tx_arbiter #(
  parameter int unsigned C_NUM_REQ        = 4,
  parameter int unsigned C_PCI_DATA_WIDTH = 128,
  parameter int unsigned C_LEN_W          = 32,
  parameter int unsigned C_OFF_W          = 31,
  parameter int unsigned C_TIMEOUT        = 1024
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [C_NUM_REQ-1:0]                  REQ_VALID,
  input  logic [C_NUM_REQ*C_LEN_W-1:0]          REQ_LEN,
  input  logic [C_NUM_REQ*C_OFF_W-1:0]          REQ_OFF,
  input  logic [C_NUM_REQ-1:0]                  REQ_LAST,
  output logic [C_NUM_REQ-1:0]                  REQ_GNT,
  output logic [C_NUM_REQ-1:0]                  REQ_DONE,
  input  logic [C_NUM_REQ*C_PCI_DATA_WIDTH-1:0] REQ_DATA,
  input  logic [C_NUM_REQ-1:0]                  REQ_DATA_VALID,
  output logic [C_NUM_REQ-1:0]                  REQ_DATA_REN,
  output logic                                  CHNL_TX,
  input  logic                                  CHNL_TX_ACK,
  output logic                                  CHNL_TX_LAST,
  output logic [C_LEN_W-1:0]                    CHNL_TX_LEN,
  output logic [C_OFF_W-1:0]                    CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA,
  output logic                                  CHNL_TX_DATA_VALID,
  input  logic                                  CHNL_TX_DATA_REN,
  output logic                                  ERR
);

  localparam int unsigned WORDS  = C_PCI_DATA_WIDTH / 32;
  localparam int unsigned WSHIFT = $clog2(WORDS);
  localparam int unsigned PTR_W  = $clog2(C_NUM_REQ);
  localparam int unsigned CNT_W  = C_LEN_W + 1;

  // Reject unsupported configurations at elaboration.
  if (C_NUM_REQ < 2 || C_NUM_REQ > 8) begin : g_bad_num_req
    $error("chnl_tx_arbiter: C_NUM_REQ must be 2..8");
  end
  if (C_TIMEOUT < 1) begin : g_bad_timeout
    $error("chnl_tx_arbiter: C_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_e;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            sel_q, sel_d;
  logic [C_NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [C_NUM_REQ-1:0]        done_q, done_d;
  logic                        tx_q, tx_d;
  logic                        last_q, last_d;
  logic [C_LEN_W-1:0]          len_q, len_d;
  logic [C_OFF_W-1:0]          off_q, off_d;
  logic [CNT_W-1:0]            beats_q, beats_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [C_LEN_W-1:0]          req_len_a  [C_NUM_REQ];
  logic [C_OFF_W-1:0]          req_off_a  [C_NUM_REQ];
  logic [C_PCI_DATA_WIDTH-1:0] req_data_a [C_NUM_REQ];

  logic                        arb_found;
  logic [PTR_W-1:0]            arb_pick;
  logic [PTR_W-1:0]            arb_cand;
  int                          arb_idx;
  logic [CNT_W-1:0]            pick_beats;
  logic                        beat_open;
  logic                        beat_acc;
  logic                        sel_dvalid;

`ifdef CHNL_TX_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(C_TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
  logic               stall_hit;
  assign stall_hit = (stall_q == STALL_W'(C_TIMEOUT - 1));
`endif

  // Unpack the flat per-requester buses.
  for (genvar g = 0; g < int'(C_NUM_REQ); g++) begin : g_unpack
    assign req_len_a[g]  = REQ_LEN[g*C_LEN_W +: C_LEN_W];
    assign req_off_a[g]  = REQ_OFF[g*C_OFF_W +: C_OFF_W];
    assign req_data_a[g] = REQ_DATA[g*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
  end

  // Round-robin pick: first valid requester at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = '0;
    arb_idx   = 0;
    for (int k = 0; k < int'(C_NUM_REQ); k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= int'(C_NUM_REQ)) arb_idx = arb_idx - int'(C_NUM_REQ);
      arb_cand = PTR_W'(arb_idx);
      if (!arb_found && REQ_VALID[arb_cand]) begin
        arb_found = 1'b1;
        arb_pick  = arb_cand;
      end
    end
  end

  // Beat count sized one bit wider than LEN so all-ones lengths cannot wrap.
  assign pick_beats = ({1'b0, req_len_a[arb_pick]} + CNT_W'(WORDS - 1)) >> WSHIFT;

  // Data path mux; closed once the granted transfer has all its beats.
  always_comb begin
    beat_open          = (state_q == ST_XFER) && (cnt_q != beats_q);
    sel_dvalid         = REQ_DATA_VALID[sel_q];
    CHNL_TX_DATA_VALID = beat_open & sel_dvalid;
    CHNL_TX_DATA       = beat_open ? req_data_a[sel_q] : '0;
    REQ_DATA_REN       = '0;
    if (beat_open) REQ_DATA_REN[sel_q] = CHNL_TX_DATA_REN;
    beat_acc           = beat_open & sel_dvalid & CHNL_TX_DATA_REN;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    tx_d    = tx_q;
    last_d  = last_q;
    len_d   = len_q;
    off_d   = off_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
`ifdef CHNL_TX_ARB_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          sel_d   = arb_pick;
          gnt_d   = C_NUM_REQ'(1) << arb_pick;
          tx_d    = 1'b1;
          last_d  = REQ_LAST[arb_pick];
          len_d   = req_len_a[arb_pick];
          off_d   = req_off_a[arb_pick];
          beats_d = pick_beats;
          cnt_d   = '0;
`ifdef CHNL_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (CHNL_TX_ACK) begin
`ifdef CHNL_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (beats_q == '0) begin
            tx_d    = 1'b0;
            gnt_d   = '0;
            done_d  = gnt_q;
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
`ifdef CHNL_TX_ARB_TIMEOUT_EN
          stall_d = stall_q + STALL_W'(1);
          if (stall_hit) begin
            tx_d    = 1'b0;
            gnt_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_XFER: begin
        if (beat_acc) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef CHNL_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q + CNT_W'(1) == beats_q) begin
            tx_d    = 1'b0;
            gnt_d   = '0;
            done_d  = gnt_q;
            state_d = ST_DONE;
          end
        end else begin
`ifdef CHNL_TX_ARB_TIMEOUT_EN
          stall_d = stall_q + STALL_W'(1);
          if (stall_hit) begin
            tx_d    = 1'b0;
            gnt_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: begin
        ptr_d   = (sel_q == PTR_W'(C_NUM_REQ - 1)) ? '0 : sel_q + PTR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      tx_q    <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
      off_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
`ifdef CHNL_TX_ARB_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      last_q  <= last_d;
      len_q   <= len_d;
      off_q   <= off_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
`ifdef CHNL_TX_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  end

  assign REQ_GNT      = gnt_q;
  assign REQ_DONE     = done_q;
  assign CHNL_TX      = tx_q;
  assign CHNL_TX_LAST = last_q;
  assign CHNL_TX_LEN  = len_q;
  assign CHNL_TX_OFF  = off_q;
`ifdef CHNL_TX_ARB_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_chnl_tx_arbiter.sv
// Directed bench for chnl_tx_arbiter: endpoint and requester models,
// scoreboard of expected grants/beats/done pulses checked at negedge.
module tb_chnl_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int LW = 32;
  localparam int OW = 31;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [LW-1:0] len;
    logic [OW-1:0] off;
    logic          last;
    int            beats;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N*LW-1:0] REQ_LEN = '0;
  logic [N*OW-1:0] REQ_OFF = '0;
  logic [N-1:0]    REQ_LAST = '0;
  logic [N-1:0]    REQ_GNT, REQ_DONE, REQ_DATA_REN;
  logic [N*DW-1:0] REQ_DATA = '0;
  logic [N-1:0]    REQ_DATA_VALID = '0;
  logic            CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID, ERR;
  logic            CHNL_TX_ACK = 1'b0;
  logic            CHNL_TX_DATA_REN = 1'b0;
  logic [LW-1:0]   CHNL_TX_LEN;
  logic [OW-1:0]   CHNL_TX_OFF;
  logic [DW-1:0]   CHNL_TX_DATA;

  int total = 0;
  int bad = 0;
  int seq[N] = '{default: 0};
  int exp_seq[N] = '{default: 0};
  logic [N-1:0] acc = '0;
  logic [N-1:0] dv_en = '1;
  logic dv_rand = 1'b0;
  logic ren_rand = 1'b0;
  int ack_delay = 0;
  int ack_cnt = 0;
  logic ack_done = 1'b0;
  txn_t exp_gnt[$];
  logic [DW-1:0] exp_data[$];
  txn_t cur = '{gnt: '0, len: '0, off: '0, last: 1'b0, beats: 0};
  int gnt_cnt = 0, done_cnt = 0, err_cnt = 0;
  int beats_seen = 0, cyc = 0, last_beat_cyc = 0;
  logic tx_prev = 1'b0;

  chnl_tx_arbiter #(
    .C_NUM_REQ(N), .C_PCI_DATA_WIDTH(DW), .C_LEN_W(LW), .C_OFF_W(OW), .C_TIMEOUT(16)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_LEN(REQ_LEN), .REQ_OFF(REQ_OFF), .REQ_LAST(REQ_LAST),
    .REQ_GNT(REQ_GNT), .REQ_DONE(REQ_DONE),
    .REQ_DATA(REQ_DATA), .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_DATA_REN(REQ_DATA_REN),
    .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
    .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
    .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN), .ERR(ERR)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkdata(input int i, input int s);
    return {32'hC0DE_0000 | 32'(i), 32'(s), ~32'(s), 32'(i * 1000 + s)};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Program requester i's fields and queue the expected grant and beats.
  task automatic push_txn(input int i, input int len, input int off, input logic last);
    txn_t t;
    t.gnt   = N'(1) << i;
    t.len   = LW'(len);
    t.off   = OW'(off);
    t.last  = last;
    t.beats = (len + 3) / 4;
    REQ_LEN[i*LW +: LW] = t.len;
    REQ_OFF[i*OW +: OW] = t.off;
    REQ_LAST[i] = last;
    exp_gnt.push_back(t);
    for (int b = 0; b < t.beats; b++) exp_data.push_back(mkdata(i, exp_seq[i] + b));
    exp_seq[i] += t.beats;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (gnt_cnt < n && k < 2000) begin @(negedge clk); k++; end
    check("wait_grants", DW'(gnt_cnt >= n), 1);
  endtask

  task automatic wait_dones(input int n);
    int k = 0;
    while (done_cnt < n && k < 2000) begin @(negedge clk); k++; end
    check("wait_dones", DW'(done_cnt >= n), 1);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats_seen < n && k < 2000) begin @(negedge clk); k++; end
    check("wait_beats", DW'(beats_seen >= n), 1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (REQ_DONE != '0) begin
      done_cnt++;
      check("done_id", REQ_DONE, cur.gnt);
      check("done_tx_low", CHNL_TX, 0);
      check("done_gnt_clr", REQ_GNT, 0);
      check("done_ren_zero", REQ_DATA_REN, 0);
      check("done_beats", DW'(beats_seen), DW'(cur.beats));
      if (cur.beats > 0) check("done_latency", DW'(cyc - last_beat_cyc), 1);
    end
    if (ERR) begin
      err_cnt++;
      check("err_tx_low", CHNL_TX, 0);
      check("err_gnt_clr", REQ_GNT, 0);
      check("err_no_done", REQ_DONE, 0);
    end
    if (!rst_n) begin
      tx_prev = 1'b0;
      acc = '0;
    end else begin
      if (CHNL_TX && !tx_prev) begin
        gnt_cnt++;
        if (exp_gnt.size() == 0) check("grant_unexpected", REQ_GNT, 0);
        else begin
          cur = exp_gnt.pop_front();
          beats_seen = 0;
          check("grant_id", REQ_GNT, cur.gnt);
          check("grant_len", CHNL_TX_LEN, cur.len);
          check("grant_off", CHNL_TX_OFF, cur.off);
          check("grant_last", CHNL_TX_LAST, cur.last);
        end
      end
      if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
        beats_seen++;
        last_beat_cyc = cyc;
        if (exp_data.size() == 0) check("beat_extra", 1, 0);
        else check("beat_data", CHNL_TX_DATA, exp_data.pop_front());
        check("len_stable", CHNL_TX_LEN, cur.len);
        check("off_stable", CHNL_TX_OFF, cur.off);
      end
      if ((REQ_DATA_REN & ~REQ_GNT) != '0) check("ren_ungranted", REQ_DATA_REN & ~REQ_GNT, 0);
      tx_prev = CHNL_TX;
      acc = REQ_DATA_REN & REQ_DATA_VALID;
    end
  end

  initial begin
    int dbase;
    // Endpoint and requester models, updated just after each rising edge.
    fork
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
          if (acc[i]) seq[i]++;
          REQ_DATA[i*DW +: DW] = mkdata(i, seq[i]);
          REQ_DATA_VALID[i] = dv_en[i] && (dv_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
        CHNL_TX_DATA_REN = ren_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!CHNL_TX) begin
          ack_cnt = 0; ack_done = 1'b0; CHNL_TX_ACK = 1'b0;
        end else if (!ack_done && ack_delay >= 0 && ack_cnt >= ack_delay) begin
          CHNL_TX_ACK = 1'b1; ack_done = 1'b1;
        end else begin
          CHNL_TX_ACK = 1'b0; ack_cnt++;
        end
      end
    join_none

    // Reset values
    #3;
    check("rst_gnt", REQ_GNT, 0);
    check("rst_done", REQ_DONE, 0);
    check("rst_tx", CHNL_TX, 0);
    check("rst_len", CHNL_TX_LEN, 0);
    check("rst_dvalid", CHNL_TX_DATA_VALID, 0);
    check("rst_ren", REQ_DATA_REN, 0);
    check("rst_err", ERR, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Requester 0, LEN=8, late ACK: two beats then done
    ack_delay = 3;
    push_txn(0, 8, 'h100, 1'b1);
    REQ_VALID[0] = 1'b1;
    wait_grants(1); step(); REQ_VALID[0] = 1'b0;
    wait_dones(1);
    check("t1_consumed", DW'(seq[0]), 2);

    // LEN=5: only two beats consumed despite continuous VALID
    ack_delay = 0;
    push_txn(1, 5, 'h2, 1'b0);
    REQ_VALID[1] = 1'b1;
    wait_grants(2); step(); REQ_VALID[1] = 1'b0;
    wait_dones(2);
    repeat (3) @(negedge clk);
    check("t2_consumed", DW'(seq[1]), 2);
    check("t2_ren_idle", REQ_DATA_REN, 0);

    // LEN=0 on requester 2: no data beats
    push_txn(2, 0, 'h3, 1'b1);
    REQ_VALID[2] = 1'b1;
    wait_grants(3); step(); REQ_VALID[2] = 1'b0;
    wait_dones(3);
    check("t3_consumed", DW'(seq[2]), 0);

    // LEN=64 with random VALID/REN bubbles on requester 3
    dv_rand = 1'b1; ren_rand = 1'b1; ack_delay = 2;
    push_txn(3, 64, 'h7F00_0000, 1'b0);
    REQ_VALID[3] = 1'b1;
    wait_grants(4); step(); REQ_VALID[3] = 1'b0;
    wait_dones(4);
    check("t4_consumed", DW'(seq[3]), 16);
    dv_rand = 1'b0; ren_rand = 1'b0; ack_delay = 0;

    // All requesting: order 0,1,2,3,0
    for (int i = 0; i < N; i++) push_txn(i, 4, 'h10 + i, 1'b1);
    push_txn(0, 4, 'h10, 1'b1);
    REQ_VALID = '1;
    wait_grants(9); step(); REQ_VALID = '0;
    wait_dones(9);

    // Reset in the middle of requester 1's transfer
    push_txn(1, 64, 'h55, 1'b1);
    REQ_VALID[1] = 1'b1;
    wait_grants(10); step(); REQ_VALID[1] = 1'b0;
    wait_beats(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", CHNL_TX, 0);
    check("mid_rst_gnt", REQ_GNT, 0);
    check("mid_rst_ren", REQ_DATA_REN, 0);
    check("mid_rst_dvalid", CHNL_TX_DATA_VALID, 0);
    check("mid_rst_data", CHNL_TX_DATA, 0);
    check("mid_rst_done", REQ_DONE, 0);
    dbase = done_cnt;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", DW'(done_cnt), DW'(dbase));
    exp_gnt.delete();
    exp_data.delete();
    exp_seq[1] = seq[1];
    step(); rst_n = 1'b1;

    // Pointer back at 0 after reset: requesters 1 then 2
    push_txn(1, 4, 'h21, 1'b0);
    push_txn(2, 4, 'h22, 1'b1);
    REQ_VALID = 4'b0110;
    wait_grants(12); step(); REQ_VALID = '0;
    wait_dones(dbase + 2);

`ifdef CHNL_TX_ARB_TIMEOUT_EN
    // Withheld ACK: watchdog releases, next grant goes to requester 0
    ack_delay = -1;
    push_txn(3, 4, 'h33, 1'b0);
    REQ_VALID[3] = 1'b1;
    wait_grants(13); step(); REQ_VALID[3] = 1'b0;
    begin
      int k = 0;
      while (err_cnt < 1 && k < 100) begin @(negedge clk); k++; end
    end
    check("timeout_err", DW'(err_cnt), 1);
    exp_data.delete();
    exp_seq[3] = seq[3];
    ack_delay = 0;
    push_txn(0, 4, 'h44, 1'b1);
    REQ_VALID = 4'b1001;
    wait_grants(14); step(); REQ_VALID = '0;
    wait_dones(dbase + 3);
`else
    check("err_quiet", DW'(err_cnt), 0);
`endif

    repeat (3) @(negedge clk);
    check("final_idle", CHNL_TX, 0);
    check("final_scoreboard", DW'(exp_gnt.size() + exp_data.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
